// File: rtl/fifo_pkg.sv
// Shared types and defaults for the shift-register FIFO and its pop-side packer.
// Holds the packer state encoding and the lane-count width helper.
// Default entry width and pack factor are shared so both ends agree.
package fifo_pkg;

   // Default FIFO entry width and entries-per-packed-word.
   localparam int FIFO_WIDTH = 4;
   localparam int FIFO_PACK  = 4;

   // FILL: popping and capturing entries; HOLD: packed word presented.
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_t;

   // Bits needed to count 0..pack lanes inclusive (log2(pack)+1).
   function automatic int lane_cnt_w(input int pack);
      return $clog2(pack) + 1;
   endfunction

endpackage

// File: rtl/fifo_pop_packer.sv
// Pops WIDTH-bit FIFO entries and packs PACK of them (first popped in lane 0) into one word.
// Latency: pop in cycle t, captured end of t+1; a full word is presented the cycle after the last capture.
// Backpressure: word held stable and popping stops while out_valid && !out_ready; flush emits a partial word.
module fifo_pop_packer
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int PACK  = FIFO_PACK,
   parameter int L2P   = $clog2(PACK)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fifo_empty,
   output logic                    fifo_pop_req,
   input  logic                    fifo_pop_ack,
   input  logic [WIDTH-1:0]        fifo_data_out,
   input  logic                    flush,
   output logic [WIDTH*PACK-1:0]   out_data,
   output logic [L2P:0]            out_lanes,
   output logic                    out_valid,
   input  logic                    out_ready
);

   // Counter width covers 0..PACK inclusive.
   localparam int CW = lane_cnt_w(PACK);
   localparam logic [CW-1:0] PACK_C = CW'(PACK);
   localparam logic [CW-1:0] ZERO_C = '0;
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   pack_state_t             state_q;
   logic [CW-1:0]           issued_q;      // pops acknowledged for the current word
   logic [CW-1:0]           captured_q;    // entries written into the lane register
   logic                    inflight_q;    // a popped entry arrives on fifo_data_out this cycle
   logic                    flush_pend_q;  // flush seen, waiting for in-flight data to land
   logic                    valid_q;
   logic [CW-1:0]           lanes_q;
   logic [WIDTH*PACK-1:0]   data_q;

   logic                    pop_fire;
   logic [CW-1:0]           cap_next;      // captured count after this cycle's capture

   // Pop request is built only from registered state and fifo_empty, never from the ack.
   assign fifo_pop_req = (state_q == FILL) && (issued_q < PACK_C) && !flush_pend_q
                         && !fifo_empty && !reset;
   assign pop_fire     = fifo_pop_req && fifo_pop_ack;
   assign cap_next     = captured_q + CW'(inflight_q);

   assign out_data  = data_q;
   assign out_lanes = lanes_q;
   assign out_valid = valid_q;

   // Packer FSM: counters, lane capture, flush handling and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FILL;
         issued_q     <= ZERO_C;
         captured_q   <= ZERO_C;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         lanes_q      <= ZERO_C;
         data_q       <= '0;
      end else begin
         case (state_q)
            FILL: begin
               inflight_q <= pop_fire;
               if (pop_fire) begin
                  issued_q <= issued_q + ONE_C;
               end
               // Registered FIFO data lands one cycle after its pop handshake.
               if (inflight_q) begin
                  captured_q <= cap_next;
                  for (int k = 0; k < PACK; k++) begin
                     if (captured_q == CW'(k)) begin
                        data_q[k*WIDTH +: WIDTH] <= fifo_data_out;
                     end
                  end
               end
               // A completed word wins over a pending flush: emit it full.
               if (cap_next == PACK_C) begin
                  state_q      <= HOLD;
                  valid_q      <= 1'b1;
                  lanes_q      <= PACK_C;
                  flush_pend_q <= 1'b0;
               end else if (flush_pend_q && !inflight_q) begin
                  if (captured_q != ZERO_C) begin
                     // Partial word: unused lanes are already zero from the last clear.
                     state_q      <= HOLD;
                     valid_q      <= 1'b1;
                     lanes_q      <= captured_q;
                     flush_pend_q <= 1'b0;
                  end else begin
                     // Nothing to emit; drop the request (a new flush may re-arm it).
                     flush_pend_q <= flush;
                  end
               end else begin
                  flush_pend_q <= flush_pend_q | flush;
               end
            end
            HOLD: begin
               // No pops in HOLD, so nothing can be in flight; flush is ignored here.
               inflight_q <= 1'b0;
               if (out_ready) begin
                  state_q      <= FILL;
                  valid_q      <= 1'b0;
                  issued_q     <= ZERO_C;
                  captured_q   <= ZERO_C;
                  flush_pend_q <= 1'b0;
                  lanes_q      <= ZERO_C;
                  data_q       <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Bench for fifo_pop_packer: behavioural FIFO front end, expected-word queue checked at output handshakes.
// Directed phases: reset, full words, backpressure hold, flush (partial, empty, same-cycle pop), mid-op reset.
// Inputs driven 1ns after rising edge; outputs sampled on the falling edge.
module tb_fifo_pop_packer;
   import fifo_pkg::*;

   localparam int WIDTH = 4;
   localparam int PACK  = 4;
   localparam int L2P   = 2;
   localparam int OW    = WIDTH * PACK;

   logic              clk = 1'b0;
   logic              reset;
   logic              fifo_empty;
   logic              fifo_pop_req;
   logic              fifo_pop_ack;
   logic [WIDTH-1:0]  fifo_data_out = '0;
   logic              flush;
   logic [OW-1:0]     out_data;
   logic [L2P:0]      out_lanes;
   logic              out_valid;
   logic              out_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_pop_packer #(.WIDTH(WIDTH), .PACK(PACK), .L2P(L2P)) dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_empty    (fifo_empty),
      .fifo_pop_req  (fifo_pop_req),
      .fifo_pop_ack  (fifo_pop_ack),
      .fifo_data_out (fifo_data_out),
      .flush         (flush),
      .out_data      (out_data),
      .out_lanes     (out_lanes),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural FIFO: combinational ack, registered read data, storage indexed by push/pop counts.
   logic [WIDTH-1:0] mem [0:255];
   int  push_cnt    = 0;
   int  pop_cnt     = 0;
   bit  drop_on_rst = 1'b0;

   assign fifo_empty   = (push_cnt == pop_cnt);
   assign fifo_pop_ack = fifo_pop_req && !fifo_empty;

   always @(posedge clk) begin
      if (reset) begin
         if (drop_on_rst) pop_cnt <= push_cnt;
      end else if (fifo_pop_req && fifo_pop_ack) begin
         fifo_data_out <= mem[pop_cnt[7:0]];
         pop_cnt       <= pop_cnt + 1;
      end
   end

   task automatic push(input logic [WIDTH-1:0] v);
      mem[push_cnt[7:0]] = v;
      push_cnt = push_cnt + 1;
   endtask

   // Expected output words, queued as stimulus is applied.
   typedef struct packed {
      logic [OW-1:0] data;
      logic [L2P:0]  lanes;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   words_seen = 0;

   task automatic expect_word(input logic [OW-1:0] d, input logic [L2P:0] l);
      exp_t e;
      e.data  = d;
      e.lanes = l;
      exp_q.push_back(e);
   endtask

   // Output monitor: every accepted word is compared against the head of the queue.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_word", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("word_data", 32'(out_data), 32'(mon_e.data));
            check_eq("word_lanes", 32'(out_lanes), 32'(mon_e.lanes));
         end
         words_seen = words_seen + 1;
      end
   end

   // Wait (bounded) until n words have been accepted; returns 1ns after a rising edge.
   task automatic wait_words(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (words_seen < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      @(posedge clk);
      #1;
      check_eq(tag, 32'(words_seen >= n), 32'd1);
   endtask

   logic [6:0] pop_pat;
   logic [6:0] val_pat;
   int         n;

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      pop_pat   = 7'b100_1111;
      val_pat   = 7'b010_0000;

      // Two words preloaded while reset is held.
      for (int i = 0; i < 8; i++) push(WIDTH'((i % 4) + 1));
      expect_word(16'h4321, 3'd4);
      expect_word(16'h4321, 3'd4);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_pop_req", 32'(fifo_pop_req), 32'd0);
      check_eq("rst_valid",   32'(out_valid),    32'd0);
      check_eq("rst_data",    32'(out_data),     32'h0000);
      check_eq("rst_lanes",   32'(out_lanes),    32'd0);

      // Release: cycle 0 starts here.
      @(posedge clk); #1 reset = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         check_eq($sformatf("pop_req_c%0d", c), 32'(fifo_pop_req), 32'(pop_pat[c]));
         check_eq($sformatf("valid_c%0d", c),   32'(out_valid),    32'(val_pat[c]));
      end

      // Second word under backpressure.
      @(posedge clk); #1 out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_reached", 32'(out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("hold_data",    32'(out_data),     32'h4321);
         check_eq("hold_lanes",   32'(out_lanes),    32'd4);
         check_eq("hold_pop_req", 32'(fifo_pop_req), 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_words(2, 5, "hold_word_accepted");
      @(negedge clk);
      check_eq("after_accept_valid", 32'(out_valid), 32'd0);
      check_eq("after_accept_data",  32'(out_data),  32'h0000);

      // Two entries, FIFO runs dry, then flush emits the partial word.
      @(posedge clk); #1;
      push(4'hA);
      push(4'hB);
      expect_word(16'h00BA, 3'd2);
      repeat (5) @(negedge clk);
      check_eq("stall_valid",   32'(out_valid),    32'd0);
      check_eq("stall_pop_req", 32'(fifo_pop_req), 32'd0);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      wait_words(3, 10, "flush_word");

      // Flush with nothing captured: no output.
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("empty_flush_valid", 32'(out_valid), 32'd0);
      end

      // Flush in the same cycle as the second pop; C and D stay in the FIFO.
      @(posedge clk); #1;
      push(4'hA);
      push(4'hB);
      push(4'hC);
      push(4'hD);
      expect_word(16'h00BA, 3'd2);
      expect_word(16'h00DC, 3'd2);
      @(negedge clk);
      check_eq("first_pop_req", 32'(fifo_pop_req), 32'd1);
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      check_eq("flush_cycle_pop_req", 32'(fifo_pop_req), 32'd1);
      @(posedge clk); #1 flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("blocked_pop_req", 32'(fifo_pop_req), 32'd0);
         check_eq("blocked_valid",   32'(out_valid),    32'd0);
      end
      @(negedge clk);
      check_eq("flush_pop_valid",   32'(out_valid),    32'd1);
      check_eq("flush_pop_pop_req", 32'(fifo_pop_req), 32'd0);
      wait_words(4, 10, "flush_pop_word");
      // Remaining C, D form a new partial word.
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      wait_words(5, 10, "tail_word");

      // Reset the cycle after a pop handshake: nothing captured, FIFO discarded.
      drop_on_rst = 1'b1;
      @(posedge clk); #1;
      push(4'h9);
      push(4'hE);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_data",    32'(out_data),     32'h0000);
      check_eq("midrst_valid",   32'(out_valid),    32'd0);
      check_eq("midrst_pop_req", 32'(fifo_pop_req), 32'd0);
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b0;
      push(4'h5);
      push(4'h6);
      push(4'h7);
      push(4'h8);
      expect_word(16'h8765, 3'd4);
      wait_words(6, 20, "reset_word");

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_pop_packer.md
# fifo_pop_packer

Downstream consumer of the shift-register FIFO. Pops WIDTH-bit entries through the FIFO's pop request/acknowledge port and packs PACK consecutive entries into one wide word, first-popped entry in lane 0 (LSBs). Presents the word on a valid/ready output. A flush input emits a partially filled word.

## Interface
- WIDTH, 4, FIFO entry width.
- PACK, 4, entries per output word; power of two, ≥2.
- L2P, 2, log2(PACK).
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop_req  out  1  pop request to FIFO.
- fifo_pop_ack  in  1  FIFO pop acknowledge (combinational from pop_req in FIFO).
- fifo_data_out  in  WIDTH  FIFO registered read data, valid the cycle after a pop handshake.
- flush  in  1  single-cycle request to emit the current partial word.
- out_data  out  WIDTH*PACK  packed word; lane k = bits [k*WIDTH +: WIDTH].
- out_lanes  out  L2P+1  number of valid lanes in out_data (1..PACK).
- out_valid  out  1  out_data/out_lanes valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- States: FILL (popping and capturing), HOLD (word presented). Reset enters FILL.
- Counters:
  - issued: L2P+1 bits, 0..PACK, pops acknowledged this word.
  - captured: L2P+1 bits, 0..PACK.
  - inflight: registered copy of fifo_pop_req && fifo_pop_ack.
- fifo_pop_req = state==FILL && issued<PACK && !flush_pend && !fifo_empty && !reset.
  - Never depends on fifo_pop_ack, so there is no combinational loop.
- Capture: when inflight=1, fifo_data_out is written to lane [captured], and captured increments.
- FILL→HOLD when either:
  - captured reaches PACK (out_lanes=PACK), or
  - flush_pend=1 && inflight=0 && captured>0 (out_lanes=captured; unused lanes driven 0).
- HOLD→FILL on out_valid && out_ready. On that transition: issued, captured and flush_pend clear, and out_data clears to 0.
- Flush:
  - flush in FILL sets flush_pend, which blocks new pops. An in-flight entry is still captured before the word is emitted.
  - flush_pend with captured==0 and inflight==0 clears with no output.
  - flush in HOLD is ignored.
  - flush in the same cycle as the PACK-th pop: the word completes normally with out_lanes=PACK, and flush_pend clears.
- No pops occur while in HOLD. out_data and out_lanes are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_lanes=0, fifo_pop_req=0, all counters 0, flush_pend=0, inflight=0.
- Pop handshake in cycle t → data sampled end of cycle t+1.
- Full word, FIFO never empty, out_ready=1: pops in cycles 0..PACK-1, out_valid high in cycle PACK+1 and accepted there, next pop in cycle PACK+2. Throughput is one word per PACK+2 cycles.
- FIFO going empty mid-word stalls pops. The partial state is retained indefinitely until more data or a flush arrives.
- Reset mid-operation:
  - Any in-flight entry and partial word are discarded.
  - The FIFO shares the reset, so no data loss is visible across reset.
  - After reset deasserts, filling restarts at lane 0.

## Structure
- Shared package fifo_pkg:
  - state enum {FILL, HOLD};
  - localparam function for lane-count width (L2P+1);
  - default WIDTH/PACK constants shared with the FIFO.
- Single module, no sub-module: FSM, counters and lane register fit inline (≈150 lines).
- Top-level integration connects fifo.pop_req/pop_ack/data_out/empty directly.

## Test plan
- Reset held with FIFO non-empty → fifo_pop_req=0, out_valid=0, out_data=16'h0000, out_lanes=0.
- FIFO preloaded 1,2,3,4, out_ready=1 → pops cycles 0-3; cycle 5 out_valid=1, out_data=16'h4321, out_lanes=4, for one cycle; next pop cycle 6.
- Full word with out_ready=0 for 10 cycles → out_data held at 16'h4321, fifo_pop_req=0 throughout; out_ready=1 → accepted, FILL resumes.
- Pop A,B, then FIFO empty, then flush → out_data=16'h00BA, out_lanes=2. A flush with 0 lanes produces no out_valid.
- Flush in the same cycle as the second pop (B) → B captured, no further pops, out_data=16'h00BA, out_lanes=2.
- Reset asserted the cycle after a pop handshake → no capture, outputs return to 0. After release, FIFO contents 5,6,7,8 → out_data=16'h8765.
